// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register file write port.
//   ADDR_W / DATA_W  register address and data widths
//   NUM_REGS         number of architectural registers (width of busy vector)
//   NOWRITE_ADDR     register that accepts handshakes but is never written
//   wr_req_t         one pending register write {addr, data}
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] NOWRITE_ADDR = 5'b11111;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // True when a request to this address must actually reach the register file.
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return (addr != NOWRITE_ADDR);
  endfunction

endpackage

// File: rtl/regfile_write_port_fifo.sv
// rf_wr_fifo: small synchronous FIFO of pending register writes.
//   clk, rst            clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data     enqueue one entry (ignored when full)
//   pop                 dequeue the head (ignored when empty)
//   head                oldest entry
//   full, empty, count  occupancy
//   entries, valid      raw storage plus per-slot valid bits, used by the
//                       owner to derive which registers are still pending
module rf_wr_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wr_req_t               push_data,
  input  logic                  pop,
  output wr_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output wr_req_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]      valid
);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  wr_req_t [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                do_push_s;
  logic                do_pop_s;

  assign full      = (count_r == CNT_DEPTH);
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign entries   = mem_r;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_r} < count_r);
    end
  end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port: sole owner of the register file write port.
//   Pipeline writeback (wb_*) has priority; long-latency returns (ll_*) are
//   queued and drain when the pipeline is idle, or forcibly once the queue has
//   lost arbitration STARVE_LIMIT cycles in a row (wb_ready drops).
//   clk, rst                          clock, asynchronous active-high reset
//   wb_valid/wb_ready/wb_addr/wb_data pipeline writeback request
//   ll_valid/ll_ready/ll_addr/ll_data long-latency return
//   write_addr/write_data/write_enable registered register file write
//   busy                              registers with a queued long-latency write
//   fifo_count                        queued entries
//   hazard_err                        sticky: wb wrote a register still queued
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 3,
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                ll_valid,
  output logic                ll_ready,
  input  logic [ADDR_W-1:0]   ll_addr,
  input  logic [DATA_W-1:0]   ll_data,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                write_enable,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    fifo_count,
  output logic                hazard_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [SW-1:0]       starve_r;
  logic [SW-1:0]       starve_next_s;
  logic                wb_fire_s;
  logic                wb_write_s;
  logic                ll_fire_s;
  logic                push_s;
  logic                pop_s;
  wr_req_t             ll_req_s;
  wr_req_t             head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  wr_req_t [DEPTH-1:0] fifo_entries_s;
  logic [DEPTH-1:0]    fifo_valid_s;

  assign wb_ready   = !rst && (starve_r < STARVE_MAX);
  assign ll_ready   = !rst && !fifo_full_s;
  assign wb_fire_s  = wb_valid && wb_ready;
  assign ll_fire_s  = ll_valid && ll_ready;
  // Requests to the non-writable register complete their handshake and vanish.
  assign wb_write_s = wb_fire_s && is_writable(wb_addr);
  assign push_s     = ll_fire_s && is_writable(ll_addr);
  // An accepted wb request holds the grant even when it targets the non-writable register.
  assign pop_s      = !wb_fire_s && !fifo_empty_s;

  assign ll_req_s.addr = ll_addr;
  assign ll_req_s.data = ll_data;

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (ll_req_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count),
    .entries   (fifo_entries_s),
    .valid     (fifo_valid_s)
  );

  // Starve counter: counts consecutive cycles the queued head lost arbitration.
  always_comb begin
    starve_next_s = starve_r;
    if (fifo_empty_s || pop_s) begin
      starve_next_s = '0;
    end else if (starve_r < STARVE_MAX) begin
      starve_next_s = starve_r + STARVE_ONE;
    end else begin
      starve_next_s = starve_r;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= '0;
    end else begin
      starve_r <= starve_next_s;
    end
  end

  // Register file write port; address/data hold their last values when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (wb_write_s) begin
      write_enable <= 1'b1;
      write_addr   <= wb_addr;
      write_data   <= wb_data;
    end else if (pop_s) begin
      write_enable <= 1'b1;
      write_addr   <= head_s.addr;
      write_data   <= head_s.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Sticky hazard flag: the pipeline overwrote a register with a queued write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_err <= 1'b0;
    end else if (wb_fire_s && busy[wb_addr]) begin
      hazard_err <= 1'b1;
    end
  end

  // Busy vector: OR of destination decodes over every occupied FIFO slot.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid_s[i]) begin
        busy[fifo_entries_s[i].addr] = 1'b1;
      end else begin
        busy = busy;
      end
    end
    busy[NOWRITE_ADDR] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Self-checking bench for regfile_write_port: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_write_port;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, ll_valid, ll_ready;
  logic [4:0]  wb_addr, ll_addr, write_addr;
  logic [31:0] wb_data, ll_data, write_data;
  logic        write_enable, hazard_err;
  logic [31:0] busy;
  logic [2:0]  fifo_count;

  regfile_write_port #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ll_valid     (ll_valid),
    .ll_ready     (ll_ready),
    .ll_addr      (ll_addr),
    .ll_data      (ll_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .hazard_err   (hazard_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  req_t        m_q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_haz;

  int          checks   = 0;
  int          failures = 0;
  logic [4:0]  wr_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (m_q[i]) b[m_q[i].addr] = 1'b1;
    b[31] = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_haz    = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("write_enable", write_enable, m_we);
    check_eq("write_addr",   write_addr,   m_addr);
    check_eq("write_data",   write_data,   m_data);
    check_eq("busy",         busy,         model_busy());
    check_eq("fifo_count",   fifo_count,   m_q.size());
    check_eq("hazard_err",   hazard_err,   m_haz);
  endtask

  // One clock cycle; called 1 time unit after a rising edge.
  task automatic cycle(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       output logic wb_acc, output logic ll_acc);
    logic exp_wr, exp_lr, pop;
    logic [31:0] b;
    req_t r;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    ll_valid = lv; ll_addr = la; ll_data = ld;
    #1;
    exp_wr = (m_starve < STARVE_LIMIT);
    exp_lr = (m_q.size() != DEPTH);
    check_eq("wb_ready", wb_ready, exp_wr);
    check_eq("ll_ready", ll_ready, exp_lr);
    wb_acc = wv && exp_wr;
    ll_acc = lv && exp_lr;
    b = model_busy();
    if (wb_acc && b[wa]) m_haz = 1'b1;
    pop = 1'b0;
    if (wb_acc) begin
      if (wa != 5'd31) begin
        m_we = 1'b1; m_addr = wa; m_data = wd;
      end else begin
        m_we = 1'b0;
      end
    end else if (m_q.size() > 0) begin
      m_we = 1'b1; m_addr = m_q[0].addr; m_data = m_q[0].data; pop = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (m_q.size() == 0 || pop) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    if (pop) void'(m_q.pop_front());
    if (ll_acc && la != 5'd31) begin
      r.addr = la; r.data = ld;
      m_q.push_back(r);
    end
    @(posedge clk);
    #1;
    check_outputs();
    if (write_enable) wr_log.push_back(write_addr);
  endtask

  task automatic idle(output logic wa_, output logic la_);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, wa_, la_);
  endtask

  // Asynchronous reset asserted between edges; called 1 time unit after an edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_write_enable", write_enable, 1'b0);
    check_eq("rst_write_addr",   write_addr,   5'd0);
    check_eq("rst_write_data",   write_data,   32'd0);
    check_eq("rst_fifo_count",   fifo_count,   3'd0);
    check_eq("rst_busy",         busy,         32'd0);
    check_eq("rst_hazard_err",   hazard_err,   1'b0);
    check_eq("rst_wb_ready",     wb_ready,     1'b0);
    check_eq("rst_ll_ready",     ll_ready,     1'b0);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    logic wa, la;
    logic [4:0] lo[$];
    int k;
    rst = 1'b1;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("reset_wb_ready", wb_ready, 1'b0);
    check_eq("reset_ll_ready", ll_ready, 1'b0);
    check_outputs();
    rst = 1'b0;

    // Single pipeline write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, wa, la);
    check_eq("wb5_we", write_enable, 1'b1);
    check_eq("wb5_addr", write_addr, 5'd5);
    check_eq("wb5_data", write_data, 32'hDEADBEEF);
    idle(wa, la);
    check_eq("wb5_we_drop", write_enable, 1'b0);

    // Single long-latency write
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h9, wa, la);
    check_eq("ll7_busy", busy[7], 1'b1);
    idle(wa, la);
    check_eq("ll7_we", write_enable, 1'b1);
    check_eq("ll7_addr", write_addr, 5'd7);
    check_eq("ll7_busy_clr", busy[7], 1'b0);
    idle(wa, la);

    // Fill the queue while the pipeline writes every cycle
    wr_log.delete();
    k = 0;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b1, 5'd20, $urandom, k < 4, 5'(k + 1), $urandom, wa, la);
      if (la) k++;
    end
    check_eq("fill_accepted", k, 4);
    foreach (wr_log[i]) if (wr_log[i] >= 5'd1 && wr_log[i] <= 5'd4) lo.push_back(wr_log[i]);
    check_eq("fill_drained", lo.size(), 4);
    foreach (lo[i]) check_eq("fill_order", lo[i], 5'(i + 1));
    idle(wa, la);

    // Both sources to the non-writable register
    cycle(1'b1, 5'd31, 32'h1111, 1'b1, 5'd31, 32'h2222, wa, la);
    check_eq("r31_wb_hs", wa, 1'b1);
    check_eq("r31_ll_hs", la, 1'b1);
    check_eq("r31_we", write_enable, 1'b0);
    check_eq("r31_count", fifo_count, 3'd0);
    idle(wa, la);

    // Hazard: wb to a register still queued
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAAAA, wa, la);
    cycle(1'b1, 5'd9, 32'hBBBB, 1'b0, 5'd0, 32'd0, wa, la);
    check_eq("haz_set", hazard_err, 1'b1);
    check_eq("haz_wb_first", write_data, 32'hBBBB);
    idle(wa, la);
    check_eq("haz_ll_second", write_data, 32'hAAAA);
    idle(wa, la);
    check_eq("haz_sticky", hazard_err, 1'b1);

    // Reset with three entries queued
    for (int c = 0; c < 3; c++) cycle(1'b1, 5'd10, $urandom, 1'b1, 5'(11 + c), $urandom, wa, la);
    check_eq("pre_rst_count", fifo_count, 3'd3);
    do_reset();
    for (int c = 0; c < 4; c++) idle(wa, la);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      logic wv, lv;
      logic [4:0] a1, a2;
      wv = ($urandom_range(0, 99) < 50);
      lv = ($urandom_range(0, 99) < 55);
      a1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle(wv, a1, $urandom, lv, a2, $urandom, wa, la);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
